mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  qualifies op as a new request in the current cycle.
REQ-006 op  input  3  request code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-007 src_a  input  32  GRF rs read data (multiplicand / dividend / MTHI-MTLO source).
REQ-008 src_b  input  32  GRF rt read data (multiplier / divisor).
REQ-009 busy  output  1  high while a MULT/MULTU/DIV/DIVU operation is in flight.
REQ-010 hi  output  32  architectural HI register, read by MFHI.
REQ-011 lo  output  32  architectural LO register, read by MFLO.

Function
REQ-012 FSM states SHALL be IDLE and BUSY only; a down-counter SHALL track the remaining busy cycles.
REQ-013 A request SHALL be accepted only when start=1, the state is IDLE, and op is not NONE/reserved.
- Requests with start=1 while in BUSY SHALL be ignored.
- op NONE and op 7 SHALL be ignored.
REQ-014 On acceptance of MULT/MULTU/DIV/DIVU at edge t:
- src_a/src_b SHALL be latched, and the result computed into pending registers.
- busy SHALL be 1 from after edge t through edge t+N, where N = MULT_CYCLES or DIV_CYCLES.
- hi/lo SHALL update at edge t+N, and busy SHALL fall at that same edge.
REQ-015 MULT SHALL form the signed 64-bit product and MULTU the unsigned 64-bit product; hi = product[63:32], lo = product[31:0].
REQ-016 DIV/DIVU SHALL produce lo = quotient and hi = remainder.
- Signed quotient SHALL truncate toward zero.
- Signed remainder SHALL take the sign of the dividend.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000, hi = 0x00000000.
REQ-018 Division by zero (src_b = 0) SHALL still hold busy for DIV_CYCLES, then leave hi/lo unchanged.
REQ-019 MTHI/MTLO accepted at edge t SHALL write src_a to hi/lo at edge t.
- busy SHALL NOT assert.
- The other register SHALL be unchanged.
REQ-020 hi/lo SHALL change only at the commit edge (REQ-014) or at an MTHI/MTLO edge; intermediate values SHALL never be visible.
REQ-021 A new request SHALL be acceptable in the cycle immediately after busy falls (back-to-back operation).
REQ-022 Changes on src_a/src_b during BUSY SHALL NOT affect the in-flight result.
REQ-023 MULT_CYCLES and DIV_CYCLES SHALL each be at least 1; the counter width SHALL be sized from the larger of the two.

Reset
REQ-024 When reset=0 at a rising edge of clk:
- hi = 0, lo = 0, busy = 0, state = IDLE, counter = 0, pending registers = 0.
REQ-025 Reset during BUSY SHALL abort the operation; no commit SHALL follow after reset releases.
REQ-026 Reset SHALL take priority over start in the same cycle.

Structure
REQ-027 The op encodings (NONE..MTLO) and the default cycle counts SHALL live in the shared package used by Controller and the datapath.
REQ-028 A combinational sub-module mdu_arith SHALL compute the 64-bit product or quotient/remainder from the latched operands and op.
- The FSM, counter and HI/LO registers SHALL remain in mdu.

Verification
REQ-029 MULT: src_a = 0xFFFFFFFE (-2), src_b = 3 -> busy high for 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-030 MULTU: src_a = 0xFFFFFFFF, src_b = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001 after 5 busy cycles.
REQ-031 DIV: src_a = 0xFFFFFFF9 (-7), src_b = 2 -> after 10 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU on the same operands -> lo = 0x7FFFFFFC, hi = 0x00000001.
REQ-032 MTHI 0x12345678 while idle -> hi = 0x12345678 at the next edge, busy stays 0; MTLO issued while busy -> lo unchanged.
REQ-033 DIV by zero with hi = 0xAAAA0000, lo = 0x5555 preloaded -> busy for 10 cycles; hi/lo unchanged.
REQ-034 Reset asserted on busy cycle 3 of a MULT -> hi = lo = 0 and busy = 0 on the following cycle; no later commit; a new MULT accepted immediately after reset releases.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, result bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

  // Request codes as presented on the op port; 7 is reserved and ignored.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Result of the arithmetic block; vld low means "leave HI/LO alone" (divide by zero).
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        vld;
  } res_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Multi-cycle operations that occupy the unit.
  function automatic logic is_long(input op_e o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product or quotient/remainder from latched operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is committed.
module mdu_arith
  import mdu_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output res_t        res
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Sign/magnitude datapath: the low 64 bits of an extended product are correct for both
  // signednesses, and dividing magnitudes then fixing signs gives truncation toward zero,
  // remainder signed like the dividend, and 0x80000000 / -1 = 0x80000000 rem 0 for free.
  always_comb begin
    res   = '0;
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    a_neg = sgn & a[31];
    b_neg = sgn & b[31];
    ext_a = {{32{a_neg}}, a};
    ext_b = {{32{b_neg}}, b};
    prod  = ext_a * ext_b;
    mag_a = a_neg ? (~a + 32'd1) : a;
    mag_b = b_neg ? (~b + 32'd1) : b;
    // Guard the divisor so a zero divisor never produces X; the result is discarded anyway.
    dvs   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / dvs;
    r_mag = mag_a % dvs;
    case (op)
      OP_MULT, OP_MULTU: begin
        res.hi  = prod[63:32];
        res.lo  = prod[31:0];
        res.vld = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res.lo  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        res.hi  = a_neg ? (~r_mag + 32'd1) : r_mag;
        res.vld = (b != 32'd0);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// HI/LO multiply-divide unit: IDLE/BUSY FSM, busy down-counter, architectural HI/LO.
// Latency: MULT*/DIV* commit MULT_CYCLES/DIV_CYCLES edges after acceptance; MTHI/MTLO same edge.
// Backpressure: busy high while an op is in flight; start during busy is dropped, not queued.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  op_e              op_q;
  op_e              op_in;
  logic             accept_long;
  logic             accept_mt;
  logic             commit;
  res_t             res;

  assign op_in = op_e'(op);
  assign busy  = (state_q == S_BUSY);

  mdu_arith u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (res)
  );

  // Next-state and strobe decode: accept only from IDLE, commit on the last busy edge.
  always_comb begin
    state_d     = state_q;
    accept_long = 1'b0;
    accept_mt   = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_long(op_in)) begin
            accept_long = 1'b1;
            state_d     = S_BUSY;
          end else if ((op_in == OP_MTHI) || (op_in == OP_MTLO)) begin
            accept_mt = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset taking priority over any request.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture and busy-cycle countdown; operands are frozen for the whole op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NONE;
    end else if (accept_long) begin
      a_q   <= src_a;
      b_q   <= src_b;
      op_q  <= op_in;
      cnt_q <= ((op_in == OP_MULT) || (op_in == OP_MULTU)) ? CNT_W'(MULT_CYCLES)
                                                          : CNT_W'(DIV_CYCLES);
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // HI/LO only move on a valid commit or an MTHI/MTLO, so no partial result is ever visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      if (res.vld) begin
        hi <= res.hi;
        lo <= res.lo;
      end
    end else if (accept_mt) begin
      if (op_in == OP_MTHI) hi <= src_a;
      else                  lo <= src_a;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: reset, MULT/MULTU/DIV/DIVU results, busy timing, MTHI/MTLO,
// divide by zero, signed overflow, ignored requests, reset abort and back-to-back issue.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total  = 0;
  int passed = 0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a request for one edge, then scramble the operand buses.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op    = 3'd0;
    src_a = 32'hDEADBEEF;
    src_b = 32'h0000_0000;
  endtask

  // Called right after the accepting edge: busy for n cycles with old HI/LO, then the new values.
  task automatic expect_long(input string tag, input int n,
                             input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] new_hi, input logic [31:0] new_lo);
    for (int k = 0; k < n; k++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_hold_hi"}, hi, old_hi);
      check({tag, "_hold_lo"}, lo, old_lo);
      tick();
    end
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, new_hi);
    check({tag, "_lo"}, lo, new_lo);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // MULT -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    expect_long("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU issued in the first cycle after busy fell
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_long("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);

    // DIV -7 / 2, then DIVU on the same bits; src_b is zeroed while busy
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    expect_long("div", 10, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    expect_long("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'h7FFF_FFFC);

    // Signed overflow case
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_long("div_ovf", 10, 32'h0000_0001, 32'h7FFF_FFFC, 32'h0000_0000, 32'h8000_0000);

    // MTHI while idle: immediate, no busy, LO untouched
    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h8000_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    // MULT 2*3, then MTLO and a second MULT while busy: both dropped
    issue(3'd1, 32'd2, 32'd3);
    issue(3'd6, 32'h0000_1111, 32'd0);
    check("mtlo_busy_lo", lo, 32'h8000_0000);
    issue(3'd2, 32'd7, 32'd7);
    expect_long("mult_ign", 3, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 32'h0000_0006);

    // op NONE and reserved op are ignored
    issue(3'd0, 32'h5555_5555, 32'd9);
    check("none_busy", {31'd0, busy}, 32'd0);
    issue(3'd7, 32'h5555_5555, 32'd9);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, 32'h0000_0000);
    check("rsvd_lo", lo, 32'h0000_0006);

    // Divide by zero with preloaded HI/LO
    issue(3'd5, 32'hAAAA_0000, 32'd0);
    issue(3'd6, 32'h0000_5555, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    expect_long("div0", 10, 32'hAAAA_0000, 32'h0000_5555, 32'hAAAA_0000, 32'h0000_5555);

    // Reset on busy cycle 3 of MULT 7*9, with start held high so reset must win
    issue(3'd1, 32'd7, 32'd9);
    tick();
    tick();
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd5;
    src_a = 32'hFFFF_0000;
    tick();
    start = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    // New MULT straight after release; old commit slot falls inside this window
    issue(3'd1, 32'd3, 32'd4);
    expect_long("post_rst", 5, 32'd0, 32'd0, 32'd0, 32'd12);
    tick();
    tick();
    check("post_rst_idle_hi", hi, 32'd0);
    check("post_rst_idle_lo", lo, 32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
